load_store_buffer: RTL and testbench

In-order load/store queue directly downstream of the load/store reservation station. Each cycle it accepts at most one operand-ready memory instruction from the station and computes the effective address at enqueue. Loads are issued from the head to the memory controller and their results are broadcast on the LSB CDB. Stores are announced to the ROB and written to memory only after the ROB commits them; on a ROB flush, speculative entries are discarded.

---
 rtl/load_store_buffer.sv | 236 +++++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_buffer.sv
// In-order load/store queue. Effective addresses are computed at enqueue and only the head issues.
// Stores are announced on the CDB first and written to memory only once the ROB has committed them.
`ifndef LSB_DEFINES
`define LSB_DEFINES
`define OPBus      3:0
`define DataBus    31:0
`define TagBus     3:0
`define AddressBus 31:0
`define LB  4'd1
`define LH  4'd2
`define LW  4'd3
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd6
`define SH  4'd7
`define SW  4'd8
`endif

module load_store_buffer #(
   parameter int DEPTH       = 16,
   parameter int FULL_MARGIN = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rdy,
   input  logic               LSB_valid,
   input  logic [`OPBus]      LSB_op,
   input  logic [`DataBus]    LSB_reg1,
   input  logic [`DataBus]    LSB_reg2,
   input  logic [`TagBus]     LSB_reg_des_rob,
   input  logic [`DataBus]    LSB_imm,
   input  logic [`AddressBus] LSB_pc,
   output logic               LSB_is_full,
   input  logic               rob_commit_valid,
   input  logic [`TagBus]     rob_commit_tag,
   input  logic               rob_flush,
   output logic               mem_req_valid,
   output logic               mem_req_we,
   output logic [`AddressBus] mem_req_addr,
   output logic [`DataBus]    mem_req_data,
   output logic [1:0]         mem_req_size,
   input  logic               mem_done,
   input  logic [`DataBus]    mem_rdata,
   output logic               LSB_cdb_valid,
   output logic [`TagBus]     LSB_cdb_tag,
   output logic [`DataBus]    LSB_cdb_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;
   state_t state_reg, state_next;

   logic [`OPBus]      op_mem   [DEPTH];
   logic [`AddressBus] addr_mem [DEPTH];
   logic [`DataBus]    data_mem [DEPTH];
   logic [`TagBus]     tag_mem  [DEPTH];
   logic [`AddressBus] pc_mem   [DEPTH];

   logic [DEPTH-1:0] committed_reg, announced_reg, valid, committed_now, keep;
   logic [AW-1:0]    head_reg, tail_reg, head_next, tail_next;
   logic [CW-1:0]    count_reg, count_next, kept;
   logic             enq, pop, issue, announce, load_done;
   logic [`OPBus]    head_op;
   logic             head_store, head_committed, head_valid;

   function automatic logic is_store(input logic [`OPBus] op);
      return (op == `SB) || (op == `SH) || (op == `SW);
   endfunction

   function automatic logic [1:0] size_of(input logic [`OPBus] op);
      case (op)
         `LB, `LBU, `SB: return 2'd0;
         `LH, `LHU, `SH: return 2'd1;
         default:        return 2'd2;
      endcase
   endfunction

   function automatic logic [`DataBus] extend(input logic [`OPBus] op, input logic [`DataBus] r);
      case (op)
         `LB:     return {{24{r[7]}}, r[7:0]};
         `LH:     return {{16{r[15]}}, r[15:0]};
         `LBU:    return {24'd0, r[7:0]};
         `LHU:    return {16'd0, r[15:0]};
         default: return r;
      endcase
   endfunction

   // Per-entry occupancy, commit match and flush survival.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [AW-1:0] offset;
         assign offset            = AW'(gi) - head_reg;
         assign valid[gi]         = {1'b0, offset} < count_reg;
         assign committed_now[gi] = committed_reg[gi] |
                                    (rob_commit_valid & valid[gi] & (tag_mem[gi] == rob_commit_tag));
         assign keep[gi]          = valid[gi] & committed_now[gi] & ~(pop & (head_reg == AW'(gi)));
      end
   endgenerate

   always_comb begin
      kept = '0;
      for (int i = 0; i < DEPTH; i++) kept = kept + CW'(keep[i]);
   end

   assign head_valid     = (count_reg != '0);
   assign head_op        = op_mem[head_reg];
   assign head_store     = is_store(head_op);
   assign head_committed = committed_now[head_reg];
   assign enq            = LSB_valid & (count_reg < CW'(DEPTH)) & ~rob_flush;
   assign LSB_is_full    = (count_reg >= CW'(DEPTH - FULL_MARGIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_reg <= IDLE;
      else if (rdy) state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (issue) state_next = BUSY;
         BUSY:    if (mem_done) state_next = IDLE;
                  else if (rob_flush && !head_store && !head_committed) state_next = DRAIN;
         DRAIN:   if (mem_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // An uncommitted head is not started in a flush cycle since the flush discards it.
   always_comb begin
      issue     = 1'b0;
      announce  = 1'b0;
      pop       = 1'b0;
      load_done = 1'b0;
      case (state_reg)
         IDLE: if (head_valid && (!rob_flush || head_committed)) begin
            if (!head_store)                  issue    = 1'b1;
            else if (!announced_reg[head_reg]) announce = 1'b1;
            else if (committed_reg[head_reg])  issue    = 1'b1;
         end
         BUSY: if (mem_done) begin
            pop       = 1'b1;
            load_done = !head_store && !rob_flush;
         end
         default: ;
      endcase
   end

   always_comb begin
      head_next = head_reg + AW'(pop);
      if (rob_flush) begin
         tail_next  = head_next + kept[AW-1:0];
         count_next = kept;
      end else begin
         tail_next  = tail_reg + AW'(enq);
         count_next = count_reg + CW'(enq) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (rdy) begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         committed_reg <= '0;
         announced_reg <= '0;
      end else if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (enq && tail_reg == AW'(i)) begin
               committed_reg[i] <= 1'b0;
               announced_reg[i] <= 1'b0;
            end else begin
               committed_reg[i] <= committed_now[i];
               if (announce && head_reg == AW'(i)) announced_reg[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && enq) begin
         op_mem[tail_reg]   <= LSB_op;
         addr_mem[tail_reg] <= LSB_reg1 + LSB_imm;
         data_mem[tail_reg] <= LSB_reg2;
         tag_mem[tail_reg]  <= LSB_reg_des_rob;
         pc_mem[tail_reg]   <= LSB_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_data  <= '0;
         mem_req_size  <= '0;
         LSB_cdb_valid <= 1'b0;
         LSB_cdb_tag   <= '0;
         LSB_cdb_data  <= '0;
      end else if (rdy) begin
         LSB_cdb_valid <= load_done | announce;
         if (load_done) begin
            LSB_cdb_tag  <= tag_mem[head_reg];
            LSB_cdb_data <= extend(head_op, mem_rdata);
         end else if (announce) begin
            LSB_cdb_tag  <= tag_mem[head_reg];
            LSB_cdb_data <= '0;
         end
         if (issue) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= head_store;
            mem_req_addr  <= addr_mem[head_reg];
            mem_req_data  <= head_store ? data_mem[head_reg] : '0;
            mem_req_size  <= size_of(head_op);
         end else if (state_reg != IDLE && mem_done) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
            mem_req_size  <= '0;
         end
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(rdy && LSB_valid && count_reg == CW'(DEPTH)));

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: a CDB scoreboard queue plus inline checks of memory requests.
`ifndef LSB_DEFINES
`define LSB_DEFINES
`define OPBus      3:0
`define DataBus    31:0
`define TagBus     3:0
`define AddressBus 31:0
`define LB  4'd1
`define LH  4'd2
`define LW  4'd3
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd6
`define SH  4'd7
`define SW  4'd8
`endif

module tb_load_store_buffer;
   logic               clk = 1'b0;
   logic               rst_n, rdy, LSB_valid, LSB_is_full;
   logic [`OPBus]      LSB_op;
   logic [`DataBus]    LSB_reg1, LSB_reg2, LSB_imm;
   logic [`TagBus]     LSB_reg_des_rob;
   logic [`AddressBus] LSB_pc;
   logic               rob_commit_valid, rob_flush;
   logic [`TagBus]     rob_commit_tag;
   logic               mem_req_valid, mem_req_we, mem_done;
   logic [`AddressBus] mem_req_addr;
   logic [`DataBus]    mem_req_data, mem_rdata;
   logic [1:0]         mem_req_size;
   logic               LSB_cdb_valid;
   logic [`TagBus]     LSB_cdb_tag;
   logic [`DataBus]    LSB_cdb_data;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] data;
   } cdb_t;
   cdb_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   load_store_buffer #(.DEPTH(16), .FULL_MARGIN(2)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .LSB_valid(LSB_valid), .LSB_op(LSB_op), .LSB_reg1(LSB_reg1), .LSB_reg2(LSB_reg2),
      .LSB_reg_des_rob(LSB_reg_des_rob), .LSB_imm(LSB_imm), .LSB_pc(LSB_pc),
      .LSB_is_full(LSB_is_full),
      .rob_commit_valid(rob_commit_valid), .rob_commit_tag(rob_commit_tag), .rob_flush(rob_flush),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag), .LSB_cdb_data(LSB_cdb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h, expected %h", name, obs, exp);
      end
   endtask

   // Every CDB pulse must match the oldest expected broadcast; lasting two cycles shows as unexpected.
   always @(negedge clk) begin
      if (rst_n && LSB_cdb_valid) begin
         if (exp_q.size() == 0) begin
            chk("cdb_unexpected_pulse", 32'(LSB_cdb_valid), 32'd0);
         end else begin
            cdb_t e;
            e = exp_q.pop_front();
            chk("cdb_tag", 32'(LSB_cdb_tag), 32'(e.tag));
            chk("cdb_data", LSB_cdb_data, e.data);
            $display("cdb   tag=%0d data=%h", LSB_cdb_tag, LSB_cdb_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] imm,
                      input logic [31:0] r2, input logic [3:0] tag);
      LSB_valid = 1'b1; LSB_op = op; LSB_reg1 = r1; LSB_imm = imm; LSB_reg2 = r2;
      LSB_reg_des_rob = tag; LSB_pc = r1 ^ 32'h0000_4000;
      $display("enq   op=%0d addr=%h data=%h tag=%0d", op, r1 + imm, r2, tag);
      tick();
      LSB_valid = 1'b0;
   endtask

   task automatic commit(input logic [3:0] tag);
      rob_commit_valid = 1'b1; rob_commit_tag = tag;
      $display("commit tag=%0d", tag);
      tick();
      rob_commit_valid = 1'b0;
   endtask

   task automatic flush();
      rob_flush = 1'b1;
      $display("flush");
      tick();
      rob_flush = 1'b0;
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 50; i++) begin
         if (mem_req_valid) break;
         tick();
      end
      chk(name, 32'(mem_req_valid), 32'd1);
   endtask

   task automatic respond(input logic [31:0] rdata);
      mem_done = 1'b1; mem_rdata = rdata;
      $display("mem   we=%0b addr=%h size=%0d wdata=%h rdata=%h",
               mem_req_we, mem_req_addr, mem_req_size, mem_req_data, rdata);
      tick();
      mem_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; LSB_valid = 1'b0; LSB_op = '0; LSB_reg1 = '0; LSB_reg2 = '0;
      LSB_imm = '0; LSB_reg_des_rob = '0; LSB_pc = '0; rob_commit_valid = 1'b0;
      rob_commit_tag = '0; rob_flush = 1'b0; mem_done = 1'b0; mem_rdata = '0;

      tick(); tick();
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_cdb_valid", 32'(LSB_cdb_valid), 32'd0);
      chk("rst_is_full", 32'(LSB_is_full), 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
      rst_n = 1'b1;
      tick();

      // LW: address 0x100 - 4, word read, broadcast one cycle after mem_done
      exp_q.push_back('{tag: 4'd3, data: 32'hDEADBEEF});
      enq(`LW, 32'h100, 32'hFFFF_FFFC, 32'h0, 4'd3);
      wait_req("lw_req");
      chk("lw_addr", mem_req_addr, 32'hFC);
      chk("lw_size", 32'(mem_req_size), 32'd2);
      chk("lw_we", 32'(mem_req_we), 32'd0);
      tick(); tick();
      chk("lw_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("lw_hold_addr", mem_req_addr, 32'hFC);
      respond(32'hDEADBEEF);
      chk("lw_cdb_next_cycle", 32'(LSB_cdb_valid), 32'd1);
      chk("lw_req_dropped", 32'(mem_req_valid), 32'd0);
      tick();
      chk("lw_cdb_one_cycle", 32'(LSB_cdb_valid), 32'd0);

      // Byte and half loads: sign vs zero extension
      exp_q.push_back('{tag: 4'd4, data: 32'hFFFFFF80});
      enq(`LB, 32'h200, 32'h1, 32'h0, 4'd4);
      wait_req("lb_req");
      chk("lb_addr", mem_req_addr, 32'h201);
      chk("lb_size", 32'(mem_req_size), 32'd0);
      respond(32'h0000_0080);
      tick();
      exp_q.push_back('{tag: 4'd6, data: 32'h00000080});
      enq(`LBU, 32'h200, 32'h2, 32'h0, 4'd6);
      wait_req("lbu_req");
      respond(32'h0000_0080);
      tick();
      exp_q.push_back('{tag: 4'd2, data: 32'hFFFF8001});
      enq(`LH, 32'h210, 32'h0, 32'h0, 4'd2);
      wait_req("lh_req");
      chk("lh_size", 32'(mem_req_size), 32'd1);
      respond(32'h5555_8001);
      tick();

      // SH: announce first with no memory access, write only after commit
      exp_q.push_back('{tag: 4'd5, data: 32'h0});
      enq(`SH, 32'h300, 32'h2, 32'h1234ABCD, 4'd5);
      tick(); tick(); tick(); tick();
      chk("sh_no_req_before_commit", 32'(mem_req_valid), 32'd0);
      commit(4'd5);
      wait_req("sh_req");
      chk("sh_we", 32'(mem_req_we), 32'd1);
      chk("sh_addr", mem_req_addr, 32'h302);
      chk("sh_size", 32'(mem_req_size), 32'd1);
      chk("sh_data", mem_req_data, 32'h1234ABCD);
      respond(32'h0);
      chk("sh_req_dropped", 32'(mem_req_valid), 32'd0);
      tick();

      // Fill to DEPTH-2 with stores (pointers wrap past 15), then drain in order
      exp_q.push_back('{tag: 4'd0, data: 32'h0});
      for (int k = 0; k < 14; k++) begin
         enq(`SW, 32'h1000, 32'(4 * k), 32'hA500_0000 + 32'(k), 4'(k));
         if (k == 12) chk("fill13_not_full", 32'(LSB_is_full), 32'd0);
      end
      chk("fill14_full", 32'(LSB_is_full), 32'd1);
      for (int k = 0; k < 14; k++) begin
         commit(4'(k));
         wait_req("fill_req");
         chk("fill_addr", mem_req_addr, 32'h1000 + 32'(4 * k));
         chk("fill_data", mem_req_data, 32'hA500_0000 + 32'(k));
         if (k < 13) exp_q.push_back('{tag: 4'(k + 1), data: 32'h0});
         respond(32'h0);
         if (k == 0) chk("pop_one_not_full", 32'(LSB_is_full), 32'd0);
      end
      tick(); tick();

      // Flush with a committed SW ahead of an uncommitted LW and SB
      exp_q.push_back('{tag: 4'd1, data: 32'h0});
      enq(`SW, 32'h400, 32'h0, 32'hCAFE_F00D, 4'd1);
      enq(`LW, 32'h500, 32'h0, 32'h0, 4'd2);
      enq(`SB, 32'h600, 32'h0, 32'h77, 4'd3);
      commit(4'd1);
      flush();
      wait_req("flush_sw_req");
      chk("flush_sw_we", 32'(mem_req_we), 32'd1);
      chk("flush_sw_addr", mem_req_addr, 32'h400);
      chk("flush_sw_data", mem_req_data, 32'hCAFE_F00D);
      respond(32'h0);
      for (int i = 0; i < 8; i++) tick();
      chk("flush_no_more_req", 32'(mem_req_valid), 32'd0);

      // Flush during an in-flight uncommitted load: request held, data discarded
      enq(`LW, 32'h700, 32'h0, 32'h0, 4'd7);
      wait_req("drain_req");
      flush();
      tick(); tick();
      chk("drain_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("drain_hold_addr", mem_req_addr, 32'h700);
      respond(32'h1111_2222);
      chk("drain_no_cdb", 32'(LSB_cdb_valid), 32'd0);
      chk("drain_req_dropped", 32'(mem_req_valid), 32'd0);
      tick();
      exp_q.push_back('{tag: 4'd8, data: 32'h3333_4444});
      enq(`LW, 32'h800, 32'h4, 32'h0, 4'd8);
      wait_req("after_drain_req");
      chk("after_drain_addr", mem_req_addr, 32'h804);
      respond(32'h3333_4444);
      tick();

      // Reset in the middle of a load clears outputs at once
      enq(`LW, 32'h40, 32'h0, 32'h0, 4'd9);
      wait_req("midrst_req");
      rst_n = 1'b0;
      #1;
      chk("midrst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_req_addr", mem_req_addr, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      exp_q.push_back('{tag: 4'd10, data: 32'h0000_00AB});
      enq(`LBU, 32'h90, 32'h0, 32'h0, 4'd10);
      wait_req("post_rst_req");
      chk("post_rst_addr", mem_req_addr, 32'h90);
      respond(32'hFFFF_FFAB);
      tick(); tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
